// File: rtl/complex_power_moving_sum.sv
// Streaming power detector: P = (re^2 + im^2) >> 1 per accepted sample, then a
// moving sum of P over the last 2**LOG_DEPTH samples, one output per input.
module complex_power_moving_sum #(
  parameter int WIDTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [2*WIDTH-1:0]            s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [2*WIDTH+LOG_DEPTH-1:0]  m_data
);

  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam int PW    = 2 * WIDTH;
  localparam int SW    = PW + LOG_DEPTH;

  // Handshake: a sample is taken when s_valid & s_ready; a result leaves when
  // m_valid & m_ready. One global enable ce advances all three stages together.
  logic ce;
  logic accept;
  logic flush;

  // Stage 1: squares
  logic                    v1_q;
  logic [PW-1:0]           re2_q;
  logic [PW-1:0]           im2_q;
  logic signed [WIDTH-1:0] re_s;
  logic signed [WIDTH-1:0] im_s;
  logic signed [PW-1:0]    re_x;
  logic signed [PW-1:0]    im_x;
  logic signed [PW-1:0]    re_sq;
  logic signed [PW-1:0]    im_sq;

  // Stage 2: power
  logic                    v2_q;
  logic [PW-1:0]           p_q;
  logic [PW:0]             pair_sum;
  logic [PW-1:0]           p_d;

  // Stage 3: window sum
  logic                    m_valid_q;
  logic [SW-1:0]           sum_q;
  logic [SW-1:0]           sum_d;
  logic [LOG_DEPTH-1:0]    wptr_q;
  logic [LOG_DEPTH-1:0]    wptr_d;
  logic [LOG_DEPTH:0]      fill_q;
  logic [LOG_DEPTH:0]      fill_d;
  logic                    full;
  logic [PW-1:0]           p_old;
  logic [PW-1:0]           hist_q [DEPTH];

  assign ce      = ~m_valid_q | m_ready;
  assign s_ready = ce & ~clear;
  assign accept  = s_valid & s_ready;
  assign flush   = reset | clear;

  assign re_s  = s_data[PW-1:WIDTH];
  assign im_s  = s_data[WIDTH-1:0];
  assign re_x  = PW'(re_s);
  assign im_x  = PW'(im_s);
  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  // Each square is at most 2**(2W-2), so the pair sum fits before the shift.
  assign pair_sum = {1'b0, re2_q} + {1'b0, im2_q};
  assign p_d      = pair_sum[PW:1];

  // Until the window has filled, the slot being overwritten holds no real sample.
  assign full   = (fill_q == (LOG_DEPTH + 1)'(DEPTH));
  assign p_old  = full ? hist_q[wptr_q] : '0;
  assign sum_d  = sum_q + SW'(p_q) - SW'(p_old);
  assign wptr_d = wptr_q + 1'b1;
  assign fill_d = full ? fill_q : fill_q + 1'b1;

  always_ff @(posedge clk) begin
    if (flush) begin
      v1_q      <= 1'b0;
      re2_q     <= '0;
      im2_q     <= '0;
      v2_q      <= 1'b0;
      p_q       <= '0;
      m_valid_q <= 1'b0;
      sum_q     <= '0;
      wptr_q    <= '0;
      fill_q    <= '0;
    end else if (ce) begin
      v1_q      <= accept;
      re2_q     <= re_sq;
      im2_q     <= im_sq;
      v2_q      <= v1_q;
      p_q       <= p_d;
      m_valid_q <= v2_q;
      if (v2_q) begin
        sum_q  <= sum_d;
        wptr_q <= wptr_d;
        fill_q <= fill_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && ce && v2_q) begin
      hist_q[wptr_q] <= p_q;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = sum_q;

endmodule

// File: tb/tb_complex_power_moving_sum.sv
// Scoreboard bench for complex_power_moving_sum (WIDTH=16, LOG_DEPTH=2).
module tb_complex_power_moving_sum;

  localparam int W  = 16;
  localparam int LD = 2;
  localparam int DW = 2 * W + LD;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          s_valid;
  logic          s_ready;
  logic [2*W-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  complex_power_moving_sum #(.WIDTH(W), .LOG_DEPTH(LD)) dut (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_acc = -1;
  int first_out = -1;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  longint        p_hist[$];

  bit            have_s = 1'b0;
  bit            bp_mode = 1'b0;
  bit            rst_req = 1'b1;
  bit            clr_req = 1'b0;
  bit            stall_prev = 1'b0;
  bit            flush_prev = 1'b0;
  logic [DW-1:0] held;
  logic signed [W-1:0] drv_re = '0;
  logic signed [W-1:0] drv_im = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: floor((re^2+im^2)/2) summed over the last four accepted samples.
  task automatic model_push();
    longint p;
    longint s;
    p = (longint'(drv_re) * longint'(drv_re) + longint'(drv_im) * longint'(drv_im)) / 2;
    p_hist.push_back(p);
    if (p_hist.size() > 4) void'(p_hist.pop_front());
    s = 0;
    foreach (p_hist[i]) s += p_hist[i];
    exp_q.push_back(DW'(s));
  endtask

  // One clock: drive at the falling edge, observe 1 time unit later.
  task automatic tick();
    @(negedge clk);
    cyc++;
    reset   = rst_req;
    clear   = clr_req;
    m_ready = (bp_mode && !rst_req && !clr_req) ? ($urandom_range(0, 1) == 1) : 1'b1;
    s_valid = have_s && !rst_req && (!bp_mode || clr_req || $urandom_range(0, 1) == 1);
    s_data  = {drv_re, drv_im};
    #1;
    if (flush_prev) check("flush_mvalid", m_valid, 0);
    if (rst_req || clr_req) begin
      if (clr_req && s_valid) check("clear_sready", s_ready, 0);
      exp_q.delete();
      p_hist.delete();
      stall_prev = 1'b0;
      flush_prev = 1'b1;
    end else begin
      flush_prev = 1'b0;
      if (stall_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held);
      end
      if (m_valid && m_ready) begin
        check("exp_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("m_data", m_data, exp_q.pop_front());
        obs_q.push_back(m_data);
        if (first_out < 0) first_out = cyc;
      end
      stall_prev = m_valid && !m_ready;
      held       = m_data;
      if (s_valid && s_ready) begin
        model_push();
        have_s = 1'b0;
        if (first_acc < 0) first_acc = cyc;
      end
    end
  endtask

  task automatic send(input int re, input int im);
    drv_re = W'(re);
    drv_im = W'(im);
    have_s = 1'b1;
    for (int i = 0; i < 100 && have_s; i++) tick();
    check("send_timeout", have_s, 0);
    have_s = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check("drain", exp_q.size(), 0);
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic do_clear();
    drv_re  = W'(99);
    drv_im  = '0;
    have_s  = 1'b1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    have_s  = 1'b0;
    obs_q.delete();
  endtask

  task automatic check_ramp(input string tag);
    logic [DW-1:0] ramp_exp [6];
    ramp_exp = '{0, 2, 6, 14, 26, 42};
    check({tag, "_count"}, obs_q.size(), 6);
    for (int i = 0; i < 6; i++) check(tag, obs_q[i], ramp_exp[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    clear   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;

    tick();
    tick();
    rst_req = 1'b0;
    tick();
    check("rst_mdata", m_data, 0);
    check("rst_sready", s_ready, 1);

    // Ramp with free-flowing output, including first-result latency.
    obs_q.delete();
    for (int r = 1; r <= 6; r++) send(r, 0);
    drain();
    check_ramp("ramp");
    check("latency", first_out - first_acc, 3);

    // Clear with samples in flight, then a fresh window.
    obs_q.delete();
    send(7, 0);
    send(8, 0);
    do_clear();
    send(2, 0);
    send(2, 0);
    drain();
    check("clr_count", obs_q.size(), 2);
    check("clr_first", obs_q[0], 2);
    check("clr_second", obs_q[1], 4);

    // 3-4-5 triangle and full-scale negative corner.
    do_clear();
    send(3, 4);
    drain();
    check("p_3_4", obs_q[0], 12);
    do_clear();
    for (int i = 0; i < 4; i++) send(-32768, -32768);
    drain();
    check("max_count", obs_q.size(), 4);
    check("max_1", obs_q[0], 64'd1 << 30);
    check("max_2", obs_q[1], 64'd1 << 31);
    check("max_3", obs_q[2], 64'd3 << 30);
    check("max_4", obs_q[3], 64'd1 << 32);

    // Ramp again under random backpressure and gaps.
    do_clear();
    bp_mode = 1'b1;
    for (int r = 1; r <= 6; r++) send(r, 0);
    drain();
    check_ramp("bp_ramp");

    // Long random run with random stalls.
    for (int i = 0; i < 1000; i++) send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    drain();
    bp_mode = 1'b0;

    // Reset in the middle of a ramp.
    for (int r = 1; r <= 4; r++) send(r, 0);
    rst_req = 1'b1;
    tick();
    tick();
    rst_req = 1'b0;
    obs_q.delete();
    send(5, 0);
    drain();
    check("rst_mid_count", obs_q.size(), 1);
    check("rst_mid_first", obs_q[0], 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
